// File: rtl/pwm_audio_pkg.sv
//------------------------------------------------------------------------------
// Module : pwm_audio_pkg
// Brief  : Shared types and defaults for the PWM audio playback path.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pwm_audio_pkg;

    localparam int unsigned DEFAULT_DIV        = 3125;
    localparam int unsigned DEFAULT_RAMP_SHIFT = 8;
    localparam int unsigned c_SAMPLE_W         = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        PLAY      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_sample_tick.sv
//------------------------------------------------------------------------------
// Module : pwm_sample_tick
// Brief  : Free-running 0..DIV-1 sample-rate counter with enable and clear.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_sample_tick #(
    parameter int unsigned DIV = 3125
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned          c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/pwm_playback_sequencer.sv
//------------------------------------------------------------------------------
// Module : pwm_playback_sequencer
// Brief  : Paces samples at the audio rate with a pop-free gain ramp on
//          start/stop, and flags underrun/overrun towards the PWM stage.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_playback_sequencer
    import pwm_audio_pkg::*;
#(
    parameter int unsigned DIV        = DEFAULT_DIV,
    parameter int unsigned RAMP_SHIFT = DEFAULT_RAMP_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    input  logic [c_SAMPLE_W-1:0] src_data,
    input  logic                  src_valid,
    output logic                  src_rdy,
    output logic [c_SAMPLE_W-1:0] pwm_data,
    output logic                  pwm_valid,
    input  logic                  pwm_rdy,
    output logic [7:0]            underrun_cnt,
    output logic                  overrun
);

    localparam int unsigned        c_G_W    = RAMP_SHIFT + 1;
    localparam int unsigned        c_PROD_W = c_SAMPLE_W + RAMP_SHIFT + 2;
    localparam logic [c_G_W-1:0]   c_GMAX   = {1'b1, {RAMP_SHIFT{1'b0}}};

    state_t                         r_state;
    state_t                         w_state_next;
    logic [c_G_W-1:0]               r_gain;
    logic [c_G_W-1:0]               w_gain_next;
    logic signed [c_SAMPLE_W-1:0]   r_last;
    logic signed [c_SAMPLE_W-1:0]   w_sample;
    logic signed [c_PROD_W-1:0]     w_sample_ext;
    logic signed [c_PROD_W-1:0]     w_gain_ext;
    logic [c_SAMPLE_W-1:0]          w_word;
    logic                           w_active;
    logic                           w_tick;
    logic                           w_emit;

    logic [c_SAMPLE_W-1:0]          r_pwm_data;
    logic                           r_pwm_valid;
    logic [7:0]                     r_underrun_cnt;
    logic                           r_overrun;

    assign w_active = (r_state != IDLE);
    assign w_emit   = w_tick & w_active;

    pwm_sample_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (w_active),
        .clr  (~w_active),
        .tick (w_tick)
    );

    // Fresh sample when offered, otherwise hold the previous one (underrun repeat).
    assign w_sample     = src_valid ? $signed(src_data) : r_last;
    assign w_sample_ext = {{(RAMP_SHIFT + 2){w_sample[c_SAMPLE_W-1]}}, w_sample};
    assign w_gain_ext   = $signed({{c_SAMPLE_W{1'b0}}, 1'b0, w_gain_next});
    assign w_word       = c_SAMPLE_W'((w_sample_ext * w_gain_ext) >>> RAMP_SHIFT);

    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        // Gain steps are clamped so a reversal at either end never wraps.
        unique case (r_state)
            IDLE: begin
                w_gain_next = '0;
                if (start && !stop) w_state_next = RAMP_UP;
            end
            RAMP_UP: begin
                w_gain_next = (r_gain >= c_GMAX) ? c_GMAX : r_gain + 1'b1;
                if (stop)                                  w_state_next = RAMP_DOWN;
                else if (w_tick && (w_gain_next == c_GMAX)) w_state_next = PLAY;
            end
            PLAY: begin
                w_gain_next = c_GMAX;
                if (stop) w_state_next = RAMP_DOWN;
            end
            RAMP_DOWN: begin
                w_gain_next = (r_gain == '0) ? '0 : r_gain - 1'b1;
                if (start && !stop)                      w_state_next = RAMP_UP;
                else if (w_tick && (w_gain_next == '0)) w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_gain_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_gain         <= '0;
            r_last         <= '0;
            r_pwm_data     <= '0;
            r_pwm_valid    <= 1'b0;
            r_underrun_cnt <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_emit) begin
                r_gain      <= w_gain_next;
                r_pwm_data  <= w_word;
                r_pwm_valid <= 1'b1;
                if (r_pwm_valid && !pwm_rdy) r_overrun <= 1'b1;
                if (src_valid) r_last <= w_sample;
                if ((r_state == PLAY) && !src_valid && (r_underrun_cnt != 8'hFF)) begin
                    r_underrun_cnt <= r_underrun_cnt + 8'd1;
                end
            end else if (r_pwm_valid && pwm_rdy) begin
                r_pwm_valid <= 1'b0;
            end
        end
    end

    assign busy         = w_active;
    assign src_rdy      = w_emit & src_valid;
    assign pwm_data     = r_pwm_data;
    assign pwm_valid    = r_pwm_valid;
    assign underrun_cnt = r_underrun_cnt;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
